// File: rtl/jam_sched_if.sv
// jam_sched bus: cost source, cost table, enumerator and result signals.
interface jam_sched_if #(
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 4
);
  logic                 start;
  logic [IDX_W-1:0]     W;
  logic [IDX_W-1:0]     J;
  logic [COST_W-1:0]    Cost;
  logic                 tbl_we;
  logic [2*IDX_W-1:0]   tbl_waddr;
  logic [COST_W-1:0]    tbl_wdata;
  logic                 perm_init;
  logic                 perm_step;
  logic                 perm_last;
  logic [SUM_W-1:0]     total_cost;
  logic                 busy;
  logic [SUM_W-1:0]     MinCost;
  logic [CNT_W-1:0]     MatchCount;
  logic                 Valid;

  modport master (
    input  start, Cost, perm_last, total_cost,
    output W, J, tbl_we, tbl_waddr, tbl_wdata,
    output perm_init, perm_step, busy,
    output MinCost, MatchCount, Valid
  );

  modport slave (
    output start, Cost, perm_last, total_cost,
    input  W, J, tbl_we, tbl_waddr, tbl_wdata,
    input  perm_init, perm_step, busy,
    input  MinCost, MatchCount, Valid
  );
endinterface

// File: rtl/jam_sched.sv
// Sequencer for the assignment cost engine: loads the cost table,
// then walks every permutation tracking the minimum cost and its count.
module jam_sched #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 4
) (
  input  logic          CLK,
  input  logic          RST,
  jam_sched_if.master   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_INIT = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [2:0]       state;
  logic [IDX_W-1:0] w;
  logic [IDX_W-1:0] j;
  logic [SUM_W-1:0] min_cost;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      w        <= '0;
      j        <= '0;
      min_cost <= '1;
      cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state <= S_LOAD;
            w     <= '0;
            j     <= '0;
          end
        end
        S_LOAD: begin
          if (j == LAST) begin
            j <= '0;
            if (w == LAST) begin
              w     <= '0;
              state <= S_INIT;
            end else begin
              w <= w + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        S_INIT: begin
          min_cost <= '1;
          cnt      <= '0;
          state    <= S_EVAL;
        end
        S_EVAL: begin
          if (bus.total_cost < min_cost) begin
            min_cost <= bus.total_cost;
            cnt      <= CNT_W'(1);
          end else if (bus.total_cost == min_cost
                       && cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          if (bus.perm_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are gated by RST so nothing is issued in the reset cycle.
  assign bus.W          = w;
  assign bus.J          = j;
  assign bus.tbl_we     = (state == S_LOAD) && !RST;
  assign bus.tbl_waddr  = {w, j};
  assign bus.tbl_wdata  = COST_W'(bus.Cost);
  assign bus.perm_init  = (state == S_INIT) && !RST;
  assign bus.perm_step  = (state == S_EVAL) && !bus.perm_last
                          && !RST;
  assign bus.busy       = (state == S_LOAD) || (state == S_INIT)
                          || (state == S_EVAL);
  assign bus.Valid      = (state == S_DONE);
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = cnt;

endmodule

// File: doc/jam_sched.md
Name: jam_sched

Overview:
- Sequencing controller for the worker/job assignment cost engine.
- Fetches the 8x8 cost matrix from the external cost source (W/J addressing) and writes it into the datapath's cost table.
- Then initialises and steps the permutation enumerator one permutation per cycle, tracking minimum total cost and the number of assignments reaching it.
- Raises Valid when the final (descending) permutation has been evaluated.

Parameters:
- N, 8, workers = jobs; matrix is N x N.
- IDX_W, 3, width of the W/J indices (clog2 N).
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of total_cost and MinCost.
- CNT_W, 4, width of MatchCount.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse; starts a run; honoured only in IDLE or DONE.
- W  out  IDX_W  worker index presented to the cost source.
- J  out  IDX_W  job index presented to the cost source.
- Cost  in  COST_W  cost for the current W/J; combinational from the source; sampled at rising edge.
- tbl_we  out  1  cost-table write strobe.
- tbl_waddr  out  2*IDX_W  write address, {W,J}.
- tbl_wdata  out  COST_W  write data (= Cost).
- perm_init  out  1  one-cycle pulse; datapath loads the identity permutation (job[i]=i).
- perm_step  out  1  advance the permutation to its lexicographic successor at the next edge.
- perm_last  in  1  current permutation is fully descending (7,6,...,0).
- total_cost  in  SUM_W  combinational cost of the current permutation.
- busy  out  1  high in LOAD, INIT, EVAL.
- MinCost  out  SUM_W  minimum total cost found.
- MatchCount  out  CNT_W  number of permutations equal to MinCost.
- Valid  out  1  result valid.

Behaviour:
- States: IDLE, LOAD, INIT, EVAL, DONE.
- Reset values: state=IDLE; W=J=0; tbl_we=perm_init=perm_step=busy=Valid=0; MinCost=all ones (1023); MatchCount=0.
- IDLE: all strobes 0. start=1 -> LOAD with W=J=0.
- LOAD:
  - tbl_we=1, tbl_waddr={W,J}, tbl_wdata=Cost, combinationally, every cycle.
  - J increments each cycle. On J=N-1: J->0 and W increments (row-major, J fastest).
  - After the write at W=J=N-1: W=J=0, go to INIT.
  - Exactly N*N=64 LOAD cycles, no gaps, no duplicate addresses.
- INIT:
  - perm_init=1 for one cycle.
  - MinCost<=1023, MatchCount<=0, then go to EVAL.
- EVAL (one permutation per cycle):
  - total_cost < MinCost: MinCost<=total_cost, MatchCount<=1.
  - total_cost == MinCost: MatchCount<=MatchCount+1, saturating at 2^CNT_W-1 (no wrap).
  - total_cost > MinCost: no change.
  - perm_last=0: perm_step=1.
  - perm_last=1: perm_step=0, go to DONE. The last permutation is still evaluated in this cycle.
- DONE:
  - Valid=1, busy=0; MinCost/MatchCount held stable.
  - start=1 -> LOAD (W=J=0). Valid drops on the same edge; results are held until INIT reloads them.
- start is ignored in LOAD, INIT and EVAL.
- Timing: start sampled at edge k -> LOAD cycles k+1..k+64, INIT k+65, EVAL k+66..k+65+P, Valid high from cycle k+66+P.
  - P = number of EVAL cycles, 40320 for a full enumeration.
- perm_init and perm_step are never high together; neither is high outside INIT/EVAL.
- RST mid-operation: next cycle is IDLE with all reset values. No tbl_we or perm_step is issued in the reset cycle or after it.
- Arithmetic is unsigned, SUM_W bits. total_cost never exceeds N*(2^COST_W-1)=1016 < 1023, so the first EVAL always updates MinCost.

Test Plan:
- Load order: Cost=8*W+J, pulse start -> 64 consecutive tbl_we cycles; tbl_waddr runs 0..63 with tbl_wdata equal to the address; perm_init exactly at k+65.
- Diagonal-zero matrix (cost=0 if W==J, else 10), full 40320-permutation stub -> MinCost=0, MatchCount=1, Valid rises at k+40386, perm_step count=40319.
- All-ones matrix -> MinCost=8, MatchCount saturates at 15 and stays 15.
- Stub asserts perm_last on the first EVAL cycle with total_cost=37 -> MinCost=37, MatchCount=1, Valid at k+67, zero perm_step pulses.
- RST asserted at LOAD cycle 30 -> state IDLE next cycle, tbl_we=0, MinCost=1023, Valid=0. A following start reloads from address 0.
- start pulsed during EVAL -> ignored (no W/J reset, no tbl_we). After DONE, a second start with a new matrix -> Valid clears at once; new correct MinCost/MatchCount at the second Valid.
